// File: rtl/musicbox_pkg.sv
// Shared types and constants for the MusicBox UI blocks.
package musicbox_pkg;

  // Recording FSM encoding; also exported through debugString[31:30].
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    DONE   = 2'd2
  } rec_fsm_t;

  // UI state values driven by MusicBoxStateController.
  localparam logic [4:0] STATE_IDLE           = 5'd0;
  localparam logic [4:0] STATE_SELECT         = 5'd1;
  localparam logic [4:0] STATE_PLAYBACK       = 5'd2;
  localparam logic [4:0] STATE_PREPARE_RECORD = 5'd3;
  localparam logic [4:0] STATE_MAKE_RECORDING = 5'd4;

  // Width of the tick counter and of elapsedTicks.
  localparam int unsigned TICK_W = 16;

endpackage

// File: rtl/musicbox_state_record_timed_if.sv
// Control, sample-in and RAM-write signals of the recording state.
interface musicbox_state_record_timed_if
  import musicbox_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned ADDR_W   = 13
);
  logic                tick_1khz;
  logic [4:0]          currentState;
  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample_data;
  logic                stop_request;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [SAMPLE_W-1:0] mem_wdata;
  logic [ADDR_W:0]     recordedLength;
  logic [TICK_W-1:0]   elapsedTicks;
  logic                stateComplete;
  logic [31:0]         debugString;

  // Controller / audio source side.
  modport master (
    output tick_1khz, currentState, sample_valid, sample_data, stop_request,
    input  mem_we, mem_addr, mem_wdata, recordedLength, elapsedTicks,
           stateComplete, debugString
  );

  // Recording block side.
  modport slave (
    input  tick_1khz, currentState, sample_valid, sample_data, stop_request,
    output mem_we, mem_addr, mem_wdata, recordedLength, elapsedTicks,
           stateComplete, debugString
  );
endinterface

// File: rtl/musicbox_tick_timer.sv
// Saturating 1 kHz tick counter with a terminal-count flag.
module musicbox_tick_timer
  import musicbox_pkg::*;
#(
  parameter int unsigned LIMIT = 5000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable,
  input  logic              tick,
  output logic [TICK_W-1:0] count,
  output logic              terminal
);

  // Count enabled ticks; clear wins, saturate at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && tick && (count != '1)) begin
      count <= count + TICK_W'(1);
    end
  end

  // The tick now arriving is the LIMIT-th one.
  assign terminal = tick && (count == TICK_W'(LIMIT - 1));

endmodule

// File: rtl/musicbox_state_record_timed.sv
// Timed recording state: streams samples to RAM until timeout, full or stop.
module musicbox_state_record_timed
  import musicbox_pkg::*;
#(
  parameter logic [4:0]  STATE_ID       = STATE_MAKE_RECORDING,
  parameter int unsigned DURATION_TICKS = 5000,
  parameter int unsigned SAMPLE_W       = 8,
  parameter int unsigned ADDR_W         = 13
) (
  input  logic clock_50Mhz,
  input  logic reset_n,
  musicbox_state_record_timed_if.slave rec
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  rec_fsm_t          fsm;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  wr_ptr_next;
  logic [TICK_W-1:0] elapsed;
  logic              in_state;
  logic              recording;
  logic              accept;
  logic              full_hit;
  logic              time_up;
  logic              finish;

  // Abort (leaving STATE_ID) suppresses every other RECORD action.
  assign in_state    = (rec.currentState == STATE_ID);
  assign recording   = (fsm == RECORD) && in_state;
  assign accept      = recording && rec.sample_valid && (wr_ptr < PTR_W'(DEPTH));
  assign wr_ptr_next = wr_ptr + PTR_W'(accept);
  assign full_hit    = accept && (wr_ptr == PTR_W'(DEPTH - 1));
  assign finish      = recording && (rec.stop_request || time_up || full_hit);

  musicbox_tick_timer #(
    .LIMIT (DURATION_TICKS)
  ) u_timer (
    .clk      (clock_50Mhz),
    .rst_n    (reset_n),
    .clear    ((fsm == IDLE) && in_state),
    .enable   (recording),
    .tick     (rec.tick_1khz),
    .count    (elapsed),
    .terminal (time_up)
  );

  // Recording FSM with registered RAM port and status outputs.
  always_ff @(posedge clock_50Mhz) begin
    if (!reset_n) begin
      fsm                <= IDLE;
      wr_ptr             <= '0;
      rec.mem_we         <= 1'b0;
      rec.mem_addr       <= '0;
      rec.mem_wdata      <= '0;
      rec.recordedLength <= '0;
      rec.stateComplete  <= 1'b0;
    end else begin
      rec.mem_we    <= accept;
      rec.mem_addr  <= accept ? wr_ptr[ADDR_W-1:0] : '0;
      rec.mem_wdata <= accept ? rec.sample_data : '0;
      case (fsm)
        IDLE: begin
          if (in_state) begin
            wr_ptr <= '0;
            fsm    <= RECORD;
          end
        end
        RECORD: begin
          if (!in_state) begin
            fsm <= IDLE;
          end else begin
            wr_ptr <= wr_ptr_next;
            if (finish) begin
              fsm                <= DONE;
              rec.recordedLength <= wr_ptr_next;
              rec.stateComplete  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (!in_state) begin
            fsm               <= IDLE;
            rec.stateComplete <= 1'b0;
          end
        end
        default: begin
          fsm               <= IDLE;
          rec.stateComplete <= 1'b0;
        end
      endcase
    end
  end

  // Status views straight off the state registers.
  assign rec.elapsedTicks = elapsed;
  assign rec.debugString  = {fsm, 1'b0, 13'(wr_ptr), elapsed};

endmodule

// File: tb/tb_musicbox_state_record_timed.sv
// Directed bench with a per-cycle behavioural model of the recording state.
module tb_musicbox_state_record_timed;
  import musicbox_pkg::*;

  localparam int unsigned SW    = 8;
  localparam int unsigned AW    = 3;
  localparam int          DUR   = 10;
  localparam int          DEPTH = 8;
  localparam logic [4:0]  SID   = 5'd4;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic [15:0] wlog[$];

  musicbox_state_record_timed_if #(.SAMPLE_W(SW), .ADDR_W(AW)) bus ();

  musicbox_state_record_timed #(
    .STATE_ID       (SID),
    .DURATION_TICKS (DUR),
    .SAMPLE_W       (SW),
    .ADDR_W         (AW)
  ) dut (
    .clock_50Mhz (clk),
    .reset_n     (rst_n),
    .rec         (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0=idle, 1=recording, 2=done; counts are plain integers.
  int m_st, m_ptr, m_ticks, m_len;
  bit e_we;
  int e_addr, e_data;

  initial begin
    bit in_st;
    bit done;
    logic [31:0] e_dbg;
    m_st = 0; m_ptr = 0; m_ticks = 0; m_len = 0;
    e_we = 0; e_addr = 0; e_data = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_st = 0; m_ptr = 0; m_ticks = 0; m_len = 0;
        e_we = 0; e_addr = 0; e_data = 0;
      end else begin
        e_we = 0; e_addr = 0; e_data = 0;
        in_st = (bus.currentState == SID);
        if (m_st == 0) begin
          if (in_st) begin
            m_st = 1; m_ptr = 0; m_ticks = 0;
          end
        end else if (!in_st) begin
          m_st = 0;
        end else if (m_st == 1) begin
          done = bus.stop_request;
          if (bus.tick_1khz) begin
            m_ticks++;
            if (m_ticks == DUR) done = 1;
          end
          if (bus.sample_valid && m_ptr < DEPTH) begin
            e_we = 1; e_addr = m_ptr; e_data = int'(bus.sample_data);
            m_ptr++;
            if (m_ptr == DEPTH) done = 1;
          end
          if (done) begin
            m_st = 2; m_len = m_ptr;
          end
        end
      end
      @(negedge clk);
      e_dbg = {2'(m_st), 1'b0, 13'(m_ptr), 16'(m_ticks)};
      check("mem_we", 64'(bus.mem_we), 64'(e_we));
      check("mem_addr", 64'(bus.mem_addr), 64'(e_addr));
      check("mem_wdata", 64'(bus.mem_wdata), 64'(e_data));
      check("stateComplete", 64'(bus.stateComplete), 64'(m_st == 2));
      check("recordedLength", 64'(bus.recordedLength), 64'(m_len));
      check("elapsedTicks", 64'(bus.elapsedTicks), 64'(m_ticks));
      check("debugString", 64'(bus.debugString), 64'(e_dbg));
      if (bus.mem_we === 1'b1) wlog.push_back({8'(bus.mem_addr), bus.mem_wdata});
    end
  end

  // Drive one cycle of inputs, then wait to the next falling edge.
  task automatic cyc(input bit sv, input logic [7:0] d, input bit tk, input bit stp);
    bus.sample_valid = sv;
    bus.sample_data  = d;
    bus.tick_1khz    = tk;
    bus.stop_request = stp;
    @(negedge clk);
  endtask

  task automatic leave_state();
    bus.currentState = 5'd0;
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 0, 0);
  endtask

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b0;
    bus.currentState = 5'd0;
    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;
    bus.tick_1khz    = 1'b0;
    bus.stop_request = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_we", 64'(bus.mem_we), 64'd0);
    check("reset_complete", 64'(bus.stateComplete), 64'd0);
    check("reset_debug", 64'(bus.debugString), 64'd0);
    rst_n = 1'b1;
    cyc(0, 8'h00, 0, 0);

    // No samples, timer runs out.
    bus.currentState = SID;
    cyc(0, 8'h00, 0, 0);
    repeat (9) begin
      cyc(0, 8'h00, 1, 0);
      cyc(0, 8'h00, 0, 0);
    end
    check("t1_not_yet", 64'(bus.stateComplete), 64'd0);
    cyc(0, 8'h00, 1, 0);
    check("t1_complete", 64'(bus.stateComplete), 64'd1);
    check("t1_len", 64'(bus.recordedLength), 64'd0);
    check("t1_ticks", 64'(bus.elapsedTicks), 64'd10);
    leave_state();
    check("t1_left", 64'(bus.stateComplete), 64'd0);

    // Five samples then timeout.
    wlog.delete();
    bus.currentState = SID;
    cyc(0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h11 + i), 0, 0);
    repeat (10) cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 0, 0);
    check("t2_len", 64'(bus.recordedLength), 64'd5);
    check("t2_nwrites", 64'(wlog.size()), 64'd5);
    if (wlog.size() == 5) begin
      check("t2_w0", 64'(wlog[0]), 64'h0011);
      check("t2_w4", 64'(wlog[4]), 64'h0415);
    end
    leave_state();

    // Eight back-to-back samples fill the RAM.
    wlog.delete();
    bus.currentState = SID;
    cyc(0, 8'h00, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 8'(8'h20 + i), 0, 0);
    check("t3_complete", 64'(bus.stateComplete), 64'd1);
    repeat (3) cyc(1, 8'hEE, 0, 0);
    check("t3_len", 64'(bus.recordedLength), 64'd8);
    check("t3_nwrites", 64'(wlog.size()), 64'd8);
    if (wlog.size() == 8) check("t3_w7", 64'(wlog[7]), 64'h0727);
    leave_state();

    // Stop request together with the fourth sample.
    wlog.delete();
    bus.currentState = SID;
    cyc(0, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'h31 + i), 0, 0);
    cyc(1, 8'h34, 0, 1);
    cyc(0, 8'h00, 0, 0);
    check("t4_len", 64'(bus.recordedLength), 64'd4);
    check("t4_complete", 64'(bus.stateComplete), 64'd1);
    check("t4_nwrites", 64'(wlog.size()), 64'd4);
    if (wlog.size() == 4) check("t4_w3", 64'(wlog[3]), 64'h0334);
    leave_state();

    // Abort after two samples; sample in the abort cycle is dropped.
    wlog.delete();
    bus.currentState = SID;
    cyc(0, 8'h00, 0, 0);
    cyc(1, 8'h41, 0, 0);
    cyc(1, 8'h42, 1, 0);
    bus.currentState = 5'd0;
    cyc(1, 8'h99, 0, 0);
    cyc(0, 8'h00, 0, 0);
    check("t5_complete", 64'(bus.stateComplete), 64'd0);
    check("t5_len_kept", 64'(bus.recordedLength), 64'd4);
    check("t5_nwrites", 64'(wlog.size()), 64'd2);
    wlog.delete();
    bus.currentState = SID;
    cyc(0, 8'h00, 0, 0);
    cyc(1, 8'h77, 0, 0);
    cyc(0, 8'h00, 1, 0);
    check("t5_reentry_n", 64'(wlog.size()), 64'd1);
    if (wlog.size() == 1) check("t5_reentry_w", 64'(wlog[0]), 64'h0077);

    // Reset pulse mid-recording.
    rst_n = 1'b0;
    cyc(1, 8'h55, 1, 0);
    check("t6_we", 64'(bus.mem_we), 64'd0);
    check("t6_addr", 64'(bus.mem_addr), 64'd0);
    check("t6_len", 64'(bus.recordedLength), 64'd0);
    check("t6_ticks", 64'(bus.elapsedTicks), 64'd0);
    check("t6_debug", 64'(bus.debugString), 64'd0);
    rst_n = 1'b1;
    leave_state();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/musicbox_state_record_timed.md
# musicbox_state_record_timed

Parametrised recording state for the MusicBox UI. While `currentState` equals `STATE_ID`, the block captures incoming audio samples into an external sample RAM. It stops on the first of three conditions: time limit, RAM full, or user stop. It then reports the recorded length and raises `stateComplete` for `MusicBoxStateController`. It replaces the fixed 5 s timer-only recording state with configurable duration, memory write-out, early stop and abort handling, all in the single `clock_50Mhz` domain.

## Interface
Parameters:
- `STATE_ID`, 5'd4: `currentState` value that activates this block.
- `DURATION_TICKS`, 5000: maximum recording length in `tick_1khz` pulses.
- `SAMPLE_W`, 8: audio sample width.
- `ADDR_W`, 13: RAM address width; capacity `DEPTH = 2**ADDR_W` samples.

Ports:
- `clock_50Mhz`, in, 1: sole clock.
- `reset_n`, in, 1: reset, synchronous, active-low.
- `tick_1khz`, in, 1: one-cycle enable pulse at 1 kHz, synchronous to `clock_50Mhz`.
- `currentState`, in, 5: UI state from the controller.
- `sample_valid`, in, 1: one-cycle strobe; `sample_data` is valid in the same cycle.
- `sample_data`, in, SAMPLE_W: audio sample.
- `stop_request`, in, 1: level; user early-stop.
- `mem_we`, out, 1: RAM write enable.
- `mem_addr`, out, ADDR_W: RAM write address.
- `mem_wdata`, out, SAMPLE_W: RAM write data.
- `recordedLength`, out, ADDR_W+1: sample count of the last completed recording.
- `elapsedTicks`, out, 16: ticks elapsed in the current or last recording.
- `stateComplete`, out, 1: recording finished; held high while in DONE.
- `debugString`, out, 32: `{fsm[1:0], 1'b0, wr_ptr zero-extended to 13 bits, elapsedTicks}`.

## Operation
- FSM states are IDLE, RECORD, DONE.
- **IDLE**
  - Outputs low; `wr_ptr` and `elapsedTicks` are held.
  - When `currentState == STATE_ID`, clear `wr_ptr` and `elapsedTicks`, then go to RECORD.
- **RECORD**
  - Each `tick_1khz` increments `elapsedTicks`.
  - Each `sample_valid` with `wr_ptr < DEPTH` writes one sample and increments `wr_ptr`.
- **RECORD exit conditions**, evaluated every cycle, leaving RECORD on the first of:
  - (a) `currentState != STATE_ID`: abort. Go to IDLE; `recordedLength` is unchanged.
  - (b) `stop_request == 1`: go to DONE.
  - (c) A tick arrives while `elapsedTicks == DURATION_TICKS-1`: go to DONE.
  - (d) A write arrives while `wr_ptr == DEPTH-1`: that sample is written, then go to DONE.
  - Priority is a > b > c = d.
- **Same-cycle events**
  - A `sample_valid` in the same cycle as exit condition b, c or d is still written.
  - A `sample_valid` in the same cycle as exit condition a is dropped.
- **DONE entry:** `recordedLength <= wr_ptr` (post-increment value).
- **DONE**
  - `stateComplete = 1`; no writes; `sample_valid` is ignored.
  - When `currentState != STATE_ID`, go to IDLE and drop `stateComplete`.
- **Arithmetic**
  - `wr_ptr` is ADDR_W+1 bits and never wraps.
  - `elapsedTicks` saturates at 16'hFFFF; it cannot reach saturation when `DURATION_TICKS ≤ 65535`, which is required.
- **Reset** (any state, including mid-recording): go to IDLE. All outputs, `wr_ptr`, `elapsedTicks` and `recordedLength` go to 0.

## Timing
- **Write latency:** `mem_we`, `mem_addr` and `mem_wdata` are registered and appear one cycle after `sample_valid`.
  - `mem_we` is high for exactly one cycle per accepted sample.
  - `mem_addr` is the pre-increment `wr_ptr`.
- **State entry:** IDLE to RECORD takes 1 cycle after `currentState` matches. The first sample accepted is the one in the cycle after entry.
- **Completion:** `stateComplete` rises the cycle after the terminating event.
- **Duration:** exactly `DURATION_TICKS` ticks are counted in RECORD before DONE.
- **Back-to-back strobes:** `sample_valid` on consecutive cycles is accepted at full rate.
- **Re-entry:** leaving and re-entering `STATE_ID` needs at least one cycle in IDLE. It starts a fresh recording from address 0.

## Structure
- **Package `musicbox_pkg`:**
  - `rec_fsm_t` enum: IDLE=2'd0, RECORD=2'd1, DONE=2'd2.
  - UI state constants, with `STATE_MAKE_RECORDING = 5'd4` used as the `STATE_ID` default.
- **Sub-module `musicbox_tick_timer`:**
  - Ports: `clear`, `enable`, `tick`, `count[15:0]`, `terminal`.
  - Parameter `LIMIT`.
  - `terminal` is asserted combinationally when `tick && count == LIMIT-1`.

## Test plan
Unless stated, the bench uses `DURATION_TICKS=10` and `ADDR_W=3`.
- Enter state 4 with no samples and 10 ticks → `stateComplete` rises 1 cycle after the 10th tick; `recordedLength=0`; `elapsedTicks=10`.
- 5 samples (0x11..0x15), then run out the timer → `mem_addr` 0..4 carry 0x11..0x15, each 1 cycle after its strobe; `recordedLength=5`.
- 8 back-to-back samples → 8 writes at addresses 0..7; DONE the cycle after the 8th; `recordedLength=8`. Further `sample_valid` produces no `mem_we`.
- `stop_request` after 3 samples, in the same cycle as a 4th `sample_valid` → 4 writes; `recordedLength=4`.
- `currentState` changes to 0 after 2 samples → IDLE, `stateComplete` stays 0, `recordedLength` keeps its prior value. Re-entering the state restarts at `mem_addr=0`.
- `reset_n=0` for one cycle mid-RECORD → next cycle all outputs are 0 and the FSM is in IDLE.
